// File: rtl/data_mem_if.sv
// CPU data-memory bus between the cpu (master) and the memory responder (slave).
interface data_mem_if;
    logic        CS;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic        RD_VALID;
    logic        FAULT;

    modport master (
        output CS, WE, ADDR, Data_BUS_WRITE,
        input  Data_BUS_READ, RD_VALID, FAULT
    );

    modport slave (
        input  CS, WE, ADDR, Data_BUS_WRITE,
        output Data_BUS_READ, RD_VALID, FAULT
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory bus slave: word RAM, fixed-latency read pipeline,
// access counters and a sticky unmapped-access fault latch.
module data_mem_responder #(
    parameter int          ADDR_W       = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_1000,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] FAULT_DATA   = 32'hDEAD_BEEF
) (
    input  logic       CLK,
    input  logic       reset,
    data_mem_if.slave  bus
);
    localparam int          DEPTH = 1 << ADDR_W;
    localparam logic [32:0] SPAN  = 33'(1) << ADDR_W;

    logic [31:0] mem [DEPTH];

    logic [31:0] ram_off, stat_off;
    logic        ram_hit, stat_hit;
    logic        rd_req, wr_ram, unmapped, stat_clr;
    logic [31:0] rdata;

    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic [READ_LATENCY-1:0][31:0] data_q;
    logic [READ_LATENCY-1:0]       vld_q;

    // RAM decode wins over the status block if the two windows overlap
    always_comb begin
        ram_off  = bus.ADDR - BASE_ADDR;
        stat_off = bus.ADDR - STAT_ADDR;
        ram_hit  = (bus.ADDR >= BASE_ADDR) && ({1'b0, ram_off} < SPAN);
        stat_hit = !ram_hit && (bus.ADDR >= STAT_ADDR) && (stat_off < 32'd4);
        rd_req   = bus.CS && !bus.WE;
        wr_ram   = bus.CS && bus.WE && ram_hit;
        unmapped = bus.CS && !ram_hit && !stat_hit;
        stat_clr = bus.CS && bus.WE && stat_hit && (stat_off[1:0] == 2'd3);
    end

    always_comb begin
        rdata = FAULT_DATA;
        if (ram_hit) begin
            rdata = mem[ram_off[ADDR_W-1:0]];
        end else if (stat_hit) begin
            unique case (stat_off[1:0])
                2'd0:    rdata = rd_cnt_q;
                2'd1:    rdata = wr_cnt_q;
                2'd2:    rdata = fault_addr_q;
                default: rdata = {31'd0, fault_q};
            endcase
        end
    end

    always_comb begin
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (rd_req && ram_hit && rd_cnt_q != 32'hFFFF_FFFF)
            rd_cnt_d = rd_cnt_q + 32'd1;
        if (wr_ram && wr_cnt_q != 32'hFFFF_FFFF)
            wr_cnt_d = wr_cnt_q + 32'd1;
        if (stat_clr) begin
            fault_d      = 1'b0;
            fault_addr_d = 32'd0;
        end
        // a fault arriving with a clear is a fresh first fault
        if (unmapped) begin
            fault_d = 1'b1;
            if (!fault_q || stat_clr)
                fault_addr_d = bus.ADDR;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ram)
            mem[ram_off[ADDR_W-1:0]] <= bus.Data_BUS_WRITE;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_cnt_q     <= 32'd0;
            wr_cnt_q     <= 32'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
            data_q       <= '0;
            vld_q        <= '0;
        end else begin
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            vld_q[0]     <= rd_req;
            if (rd_req)
                data_q[0] <= rdata;
            // each stage only loads on a valid, so the last one holds
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1])
                    data_q[i] <= data_q[i-1];
            end
        end
    end

    assign bus.Data_BUS_READ = data_q[READ_LATENCY-1];
    assign bus.RD_VALID      = vld_q[READ_LATENCY-1];
    assign bus.FAULT         = fault_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders at read latency 1, 2 and 3.
module tb_data_mem_responder;
    localparam logic [31:0] STAT = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst1, rst2, rst3;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    data_mem_if b1();
    data_mem_if b2();
    data_mem_if b3();

    data_mem_responder #(.READ_LATENCY(1)) u1 (.CLK(clk), .reset(rst1), .bus(b1));
    data_mem_responder #(.READ_LATENCY(2)) u2 (.CLK(clk), .reset(rst2), .bus(b2));
    data_mem_responder #(.READ_LATENCY(3)) u3 (.CLK(clk), .reset(rst3), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d);
        b1.CS = 1'b1; b1.WE = 1'b1; b1.ADDR = a; b1.Data_BUS_WRITE = d;
        tick();
        b1.CS = 1'b0; b1.WE = 1'b0;
    endtask

    task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] exp);
        b1.CS = 1'b1; b1.WE = 1'b0; b1.ADDR = a;
        tick();
        b1.CS = 1'b0;
        chk({tag, "_vld"}, 32'(b1.RD_VALID), 32'd1);
        chk(tag, b1.Data_BUS_READ, exp);
    endtask

    task automatic wr3(input logic [31:0] a, input logic [31:0] d);
        b3.CS = 1'b1; b3.WE = 1'b1; b3.ADDR = a; b3.Data_BUS_WRITE = d;
        tick();
        b3.CS = 1'b0; b3.WE = 1'b0;
    endtask

    initial begin
        b1.CS = 0; b1.WE = 0; b1.ADDR = 0; b1.Data_BUS_WRITE = 0;
        b2.CS = 0; b2.WE = 0; b2.ADDR = 0; b2.Data_BUS_WRITE = 0;
        b3.CS = 0; b3.WE = 0; b3.ADDR = 0; b3.Data_BUS_WRITE = 0;
        rst1 = 1; rst2 = 1; rst3 = 1;
        tick(); tick();
        chk("rst_data", b1.Data_BUS_READ, 32'd0);
        chk("rst_vld", 32'(b1.RD_VALID), 32'd0);
        chk("rst_fault", 32'(b1.FAULT), 32'd0);
        rst1 = 0; rst2 = 0; rst3 = 0;

        rd1("rst_rdcnt", STAT + 0, 32'd0);
        rd1("rst_wrcnt", STAT + 1, 32'd0);

        wr1(32'd5, 32'h22B4);
        rd1("raw_5", 32'd5, 32'h22B4);
        tick();
        chk("idle_vld", 32'(b1.RD_VALID), 32'd0);
        chk("idle_hold", b1.Data_BUS_READ, 32'h22B4);
        rd1("wrcnt_1", STAT + 1, 32'd1);
        rd1("rdcnt_1", STAT + 0, 32'd1);

        wr1(32'h0000_2000, 32'h1234_5678);
        chk("fault_set", 32'(b1.FAULT), 32'd1);
        rd1("unmapped_rd", 32'h0000_3000, 32'hDEAD_BEEF);
        rd1("fault_addr", STAT + 2, 32'h0000_2000);
        rd1("fault_flag", STAT + 3, 32'd1);
        wr1(STAT + 3, 32'hFFFF_FFFF);
        chk("fault_clr", 32'(b1.FAULT), 32'd0);
        rd1("fault_addr_clr", STAT + 2, 32'd0);
        rd1("fault_flag_clr", STAT + 3, 32'd0);
        wr1(STAT + 0, 32'h55);
        chk("stat_ro_nofault", 32'(b1.FAULT), 32'd0);
        rd1("wrcnt_still_1", STAT + 1, 32'd1);
        rd1("rdcnt_still_1", STAT + 0, 32'd1);

        force u1.wr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release u1.wr_cnt_q;
        wr1(32'd7, 32'h77);
        rd1("wrcnt_sat", STAT + 1, 32'hFFFF_FFFF);
        rd1("ram_7", 32'd7, 32'h77);

        wr3(32'd0, 32'hA);
        wr3(32'd1, 32'hB);
        wr3(32'd2, 32'hC);
        b3.CS = 1; b3.WE = 0; b3.ADDR = 32'd0;
        tick();
        chk("l3_e0_vld", 32'(b3.RD_VALID), 32'd0);
        b3.ADDR = 32'd1;
        tick();
        chk("l3_e1_vld", 32'(b3.RD_VALID), 32'd0);
        b3.ADDR = 32'd2;
        tick();
        b3.CS = 0;
        chk("l3_a_vld", 32'(b3.RD_VALID), 32'd1);
        chk("l3_a", b3.Data_BUS_READ, 32'hA);
        tick();
        chk("l3_b_vld", 32'(b3.RD_VALID), 32'd1);
        chk("l3_b", b3.Data_BUS_READ, 32'hB);
        tick();
        chk("l3_c_vld", 32'(b3.RD_VALID), 32'd1);
        chk("l3_c", b3.Data_BUS_READ, 32'hC);
        tick();
        chk("l3_drain_vld", 32'(b3.RD_VALID), 32'd0);
        chk("l3_hold", b3.Data_BUS_READ, 32'hC);

        b2.CS = 1; b2.WE = 1; b2.ADDR = 32'd9; b2.Data_BUS_WRITE = 32'h5A5A;
        tick();
        b2.WE = 0;
        tick();
        b2.CS = 0;
        rst2 = 1;
        tick();
        rst2 = 0;
        chk("l2_rst_vld", 32'(b2.RD_VALID), 32'd0);
        chk("l2_rst_data", b2.Data_BUS_READ, 32'd0);
        tick();
        chk("l2_post_vld", 32'(b2.RD_VALID), 32'd0);
        b2.CS = 1; b2.WE = 0; b2.ADDR = 32'd9;
        tick();
        b2.CS = 0;
        chk("l2_e0_vld", 32'(b2.RD_VALID), 32'd0);
        tick();
        chk("l2_ret_vld", 32'(b2.RD_VALID), 32'd1);
        chk("l2_retained", b2.Data_BUS_READ, 32'h5A5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
